// File: rtl/proc_control_fsm.sv
// Multi-cycle control sequencer for the 10-bit shared-bus processor.
// It decodes the captured instruction into register, ALU and bus strobes, one state per cycle.
module proc_control_fsm (
  input  logic       CLKb,
  input  logic       Rst,
  input  logic       Exec,
  input  logic [9:0] INST,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Extern,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic [3:0] FN,
  output logic       Done,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t     state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic [3:0] opcode;
  logic [7:0] rxSel;
  logic [7:0] rySel;
  logic       isAluOp;

  assign opcode  = ir_q[9:6];
  assign rxSel   = 8'b1 << ir_q[5:3];
  assign rySel   = 8'b1 << ir_q[2:0];
  assign isAluOp = (opcode >= 4'd2) && (opcode <= 4'd5);

  // The datapath samples on the falling edge, so the sequencer advances on it too.
  always_ff @(negedge CLKb or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    Rin     = '0;
    Rout    = '0;
    Extern  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    FN      = '0;
    Done    = 1'b0;
    Busy    = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (Exec) begin
          ir_d    = INST;
          state_d = T1;
        end
      end
      T1: begin
        state_d = IDLE;
        if (opcode == 4'd0) begin
          Extern = 1'b1;
          Rin    = rxSel;
          Done   = 1'b1;
        end else if (opcode == 4'd1) begin
          Rout = rySel;
          Rin  = rxSel;
          Done = 1'b1;
        end else if (isAluOp) begin
          Rout    = rySel;
          Ain     = 1'b1;
          state_d = T2;
        end else begin
          Done = 1'b1;
        end
      end
      // Rx goes on the bus as the ALU's second operand, so SUB computes Rx - Ry.
      T2: begin
        Rout    = rxSel;
        Gin     = 1'b1;
        state_d = T3;
        case (opcode)
          4'd2:    FN = 4'b0001;
          4'd3:    FN = 4'b0010;
          4'd4:    FN = 4'b0100;
          4'd5:    FN = 4'b1000;
          default: FN = 4'b0000;
        endcase
      end
      T3: begin
        Gout    = 1'b1;
        Rin     = rxSel;
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: stimulus pushes expected per-cycle strobe vectors,
// a monitor pops them on every busy cycle; a small register/ALU model checks end results.
module tb_proc_control_fsm;

  logic       CLKb;
  logic       Rst;
  logic       Exec;
  logic [9:0] INST;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       Extern;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [3:0] FN;
  logic       Done;
  logic       Busy;

  int totalCount = 0;
  int badCount   = 0;

  logic [24:0] expQ[$];
  logic [9:0]  extData;
  logic [9:0]  regs[8];
  logic [9:0]  aReg;
  logic [9:0]  gReg;
  logic [24:0] outVec;

  proc_control_fsm dut (
    .CLKb  (CLKb),
    .Rst   (Rst),
    .Exec  (Exec),
    .INST  (INST),
    .Rin   (Rin),
    .Rout  (Rout),
    .Extern(Extern),
    .Ain   (Ain),
    .Gin   (Gin),
    .Gout  (Gout),
    .FN    (FN),
    .Done  (Done),
    .Busy  (Busy)
  );

  assign outVec = {Rin, Rout, Extern, Ain, Gin, Gout, FN, Done};

  initial begin
    CLKb = 1'b1;
    forever #5 CLKb = ~CLKb;
  end

  function automatic logic [24:0] mk(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic ext, input logic ain, input logic gin,
                                     input logic gout, input logic [3:0] fn, input logic done);
    return {rin, rout, ext, ain, gin, gout, fn, done};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    totalCount++;
    if (got !== want) begin
      badCount++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Expected strobe sequence derived from the instruction set description.
  task automatic pushExpect(input logic [9:0] inst);
    logic [3:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] fn;
    op = inst[9:6];
    x  = 8'b1 << inst[5:3];
    y  = 8'b1 << inst[2:0];
    fn = 4'b0000;
    case (op)
      4'd2: fn = 4'b0001;
      4'd3: fn = 4'b0010;
      4'd4: fn = 4'b0100;
      4'd5: fn = 4'b1000;
      default: fn = 4'b0000;
    endcase
    if (op == 4'd0) expQ.push_back(mk(x, 8'h00, 1, 0, 0, 0, 4'h0, 1));
    else if (op == 4'd1) expQ.push_back(mk(x, y, 0, 0, 0, 0, 4'h0, 1));
    else if (op >= 4'd2 && op <= 4'd5) begin
      expQ.push_back(mk(8'h00, y, 0, 1, 0, 0, 4'h0, 0));
      expQ.push_back(mk(8'h00, x, 0, 0, 1, 0, fn, 0));
      expQ.push_back(mk(x, 8'h00, 0, 0, 0, 1, 4'h0, 1));
    end else expQ.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1));
  endtask

  task automatic applyStimulus(input logic [9:0] inst, input logic [9:0] ext);
    int n;
    @(posedge CLKb);
    extData = ext;
    INST    = inst;
    Exec    = 1'b1;
    @(posedge CLKb);
    Exec = 1'b0;
    INST = ~inst;
    n = 0;
    while (Busy && n < 8) begin
      @(posedge CLKb);
      n++;
    end
    if (Busy) checkOutput("timeout", {31'd0, Busy}, 32'd0);
  endtask

  // Register file and ALU model driven by the DUT strobes, updated on the datapath edge.
  always @(negedge CLKb) begin
    logic [9:0] bus;
    bus = 10'd0;
    if (Extern) bus = extData;
    else if (Gout) bus = gReg;
    else for (int i = 0; i < 8; i++) if (Rout[i]) bus = regs[i];
    if (!Rst) begin
      if (Ain) aReg <= bus;
      if (Gin) begin
        case (FN)
          4'b0001: gReg <= bus + aReg;
          4'b0010: gReg <= bus - aReg;
          4'b0100: gReg <= bus & aReg;
          4'b1000: gReg <= bus | aReg;
          default: gReg <= gReg;
        endcase
      end
      for (int i = 0; i < 8; i++) if (Rin[i]) regs[i] <= bus;
    end
  end

  always @(posedge CLKb) begin
    logic [24:0] want;
    logic        exclOk;
    if (!Rst) begin
      if (Busy) begin
        if (expQ.size() == 0) begin
          totalCount++;
          badCount++;
          $display("[TB] FAIL unexpected busy: got %h want idle at %0t", outVec, $time);
        end else begin
          want = expQ.pop_front();
          checkOutput("seq", {7'd0, outVec}, {7'd0, want});
        end
      end else begin
        checkOutput("idle", {7'd0, outVec}, 32'd0);
      end
      exclOk = (($countones(Rout) + Extern + Gout) <= 1) && $onehot0(Rin) && $onehot0(Rout);
      checkOutput("bus excl", {31'd0, exclOk}, 32'd1);
      checkOutput("fn outside T2", {31'd0, (FN == 4'd0) || Gin}, 32'd1);
    end
  end

  initial begin
    logic [9:0] saved;
    Rst     = 1'b1;
    Exec    = 1'b0;
    INST    = '0;
    extData = '0;
    aReg    = '0;
    gReg    = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    #2;
    checkOutput("reset outs", {7'd0, outVec}, 32'd0);
    checkOutput("reset busy", {31'd0, Busy}, 32'd0);
    @(posedge CLKb);
    Rst = 1'b0;

    // LOAD R3 from external input.
    expQ.push_back(mk(8'h08, 8'h00, 1, 0, 0, 0, 4'h0, 1));
    applyStimulus(10'b0000_011_000, 10'h2A5);
    checkOutput("R3 load", {22'd0, regs[3]}, 32'h2A5);

    // R1=5, R2=3, then ADD R1,R2.
    expQ.push_back(mk(8'h02, 8'h00, 1, 0, 0, 0, 4'h0, 1));
    applyStimulus(10'b0000_001_000, 10'd5);
    expQ.push_back(mk(8'h04, 8'h00, 1, 0, 0, 0, 4'h0, 1));
    applyStimulus(10'b0000_010_000, 10'd3);
    expQ.push_back(mk(8'h00, 8'h04, 0, 1, 0, 0, 4'h0, 0));
    expQ.push_back(mk(8'h00, 8'h02, 0, 0, 1, 0, 4'h1, 0));
    expQ.push_back(mk(8'h02, 8'h00, 0, 0, 0, 1, 4'h0, 1));
    applyStimulus(10'b0010_001_010, 10'd0);
    checkOutput("R1 add", {22'd0, regs[1]}, 32'd8);

    // Abort an ADD in T2 with an asynchronous reset.
    expQ.push_back(mk(8'h00, 8'h04, 0, 1, 0, 0, 4'h0, 0));
    expQ.push_back(mk(8'h00, 8'h02, 0, 0, 1, 0, 4'h1, 0));
    @(posedge CLKb);
    INST = 10'b0010_001_010;
    Exec = 1'b1;
    @(posedge CLKb);
    Exec = 1'b0;
    @(posedge CLKb);
    #1 Rst = 1'b1;
    #1;
    checkOutput("abort outs", {7'd0, outVec}, 32'd0);
    checkOutput("abort busy", {31'd0, Busy}, 32'd0);
    expQ.delete();
    repeat (2) @(posedge CLKb);
    Rst = 1'b0;
    repeat (3) @(posedge CLKb);
    checkOutput("abort R1 kept", {22'd0, regs[1]}, 32'd8);
    checkOutput("abort idle", {31'd0, Busy}, 32'd0);

    // SUB wrap: R1=2, R2=5 gives 2-5 mod 1024.
    expQ.push_back(mk(8'h02, 8'h00, 1, 0, 0, 0, 4'h0, 1));
    applyStimulus(10'b0000_001_000, 10'd2);
    expQ.push_back(mk(8'h04, 8'h00, 1, 0, 0, 0, 4'h0, 1));
    applyStimulus(10'b0000_010_000, 10'd5);
    expQ.push_back(mk(8'h00, 8'h04, 0, 1, 0, 0, 4'h0, 0));
    expQ.push_back(mk(8'h00, 8'h02, 0, 0, 1, 0, 4'h2, 0));
    expQ.push_back(mk(8'h02, 8'h00, 0, 0, 0, 1, 4'h0, 1));
    applyStimulus(10'b0011_001_010, 10'd0);
    checkOutput("R1 sub wrap", {22'd0, regs[1]}, 32'h3FD);

    // Exec held high: MOVE R0<-R7 repeats every second cycle.
    expQ.push_back(mk(8'h80, 8'h00, 1, 0, 0, 0, 4'h0, 1));
    applyStimulus(10'b0000_111_000, 10'h155);
    for (int i = 0; i < 4; i++) expQ.push_back(mk(8'h01, 8'h80, 0, 0, 0, 0, 4'h0, 1));
    @(posedge CLKb);
    INST = 10'b0001_000_111;
    Exec = 1'b1;
    repeat (8) @(posedge CLKb);
    Exec = 1'b0;
    repeat (2) @(posedge CLKb);
    checkOutput("held exec drained", expQ.size(), 32'd0);
    checkOutput("R0 move", {22'd0, regs[0]}, 32'h155);

    // Opcode 1010 is a NOP: Done only.
    saved = regs[5];
    expQ.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1));
    applyStimulus(10'b1010_101_011, 10'h3FF);
    checkOutput("nop R5", {22'd0, regs[5]}, {22'd0, saved});

    // Random instruction stream.
    for (int i = 0; i < 1000; i++) begin
      logic [9:0] inst;
      inst = 10'($urandom);
      pushExpect(inst);
      applyStimulus(inst, 10'($urandom));
    end
    repeat (2) @(posedge CLKb);
    checkOutput("queue empty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
